// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner: time-multiplexed 4-digit common-anode hex display driver.
// Shares one external decoder, blanks between slots, loads at frame edges.
module sevenseg_scanner #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  output logic                   load_ack,
  input  logic                   lz_blank,
  output logic [3:0]             dec_address,
  input  logic [6:0]             dec_data,
  output logic [6:0]             segments,
  output logic [NDIGITS-1:0]     digit_en,
  output logic                   frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
  logic [6:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     den_q, den_d;
  logic                   ack_q, ack_d;
  logic                   fdone_q, fdone_d;

  logic [3:0]             nib [NDIGITS];
  logic [NDIGITS-1:0]     hz;
  logic                   lz_hide;
  logic                   slot_end;
  logic                   last_dig;

  // Split the shadow register into per-digit nibbles.
  always_comb begin
    for (int k = 0; k < NDIGITS; k++) begin
      nib[k] = shadow_q[4*k +: 4];
    end
  end

  // hz[k]: nibbles k..NDIGITS-1 are all zero (leading-zero run).
  always_comb begin
    logic run;
    run = 1'b1;
    hz  = '0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      run   = run && (nib[k] == 4'h0);
      hz[k] = run;
    end
  end

  assign lz_hide  = lz_blank && (idx_q != '0) && hz[idx_q];
  assign slot_end = (cnt_q == CW'(PRESCALE - 1));
  assign last_dig = (idx_q == IW'(NDIGITS - 1));

  // Current digit's nibble goes to the decoder for the whole slot.
  assign dec_address = nib[idx_q];

  // Slot sequencing, frame-edge capture and next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    seg_d    = 7'h7F;
    den_d    = '1;
    ack_d    = 1'b0;
    fdone_d  = 1'b0;
    unique case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK - 1)) begin
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (slot_end) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = last_dig ? '0 : idx_q + IW'(1);
          if (last_dig) begin
            fdone_d = 1'b1;
            if (load) begin
              shadow_d = value;
              ack_d    = 1'b1;
            end
          end
        end
      end
    endcase
    if (state_d == S_SHOW && !lz_hide) begin
      den_d[idx_q] = 1'b0;
      seg_d        = dec_data;
    end
  end

  // State and registered display outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= 7'h7F;
      den_q    <= '1;
      ack_q    <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      den_q    <= den_d;
      ack_q    <= ack_d;
      fdone_q  <= fdone_d;
    end
  end

  assign segments   = seg_q;
  assign digit_en   = den_q;
  assign load_ack   = ack_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// tb_sevenseg_scanner: randomized frames checked by a frame-level scoreboard.
// Stimulus pushes per-frame expectations; a monitor checks every cycle.
module tb_sevenseg_scanner;

  localparam int ND  = 4;
  localparam int PS  = 8;
  localparam int BL  = 2;
  localparam int FR  = ND * PS;
  localparam int NFR = 30;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        load_ack;
  logic        lz_blank;
  logic [3:0]  dec_address;
  logic [6:0]  dec_data;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] sh;
    logic        lz;
    logic        ack;
    logic        first;
  } rec_t;

  rec_t sb[$];

  int          mode [NFR];
  logic [15:0] val  [NFR];
  logic        lzc  [NFR];
  int          s_c  [NFR];
  int          e_c  [NFR];

  logic [15:0] shadow_m;

  sevenseg_scanner #(
    .NDIGITS(ND), .PRESCALE(PS), .BLANK(BL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .value(value),
    .load(load),
    .load_ack(load_ack),
    .lz_blank(lz_blank),
    .dec_address(dec_address),
    .dec_data(dec_data),
    .segments(segments),
    .digit_en(digit_en),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] segf(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign dec_data = segf(dec_address);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs in cycle c of a frame showing s with blanking lz.
  task automatic exp_cyc(input logic [15:0] s, input logic lz,
                         input int c, output logic [3:0] den,
                         output logic [6:0] seg, output logic [3:0] adr);
    int k;
    int p;
    logic [15:0] hi;
    logic vis;
    k   = c / PS;
    p   = c % PS;
    hi  = s >> (4 * k);
    adr = hi[3:0];
    vis = (p >= BL) && !(lz && k >= 1 && hi == 16'h0);
    den = 4'hF;
    seg = 7'h7F;
    if (vis) begin
      den = ~(4'b0001 << k);
      seg = segf(adr);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [15:0] s,
                             input logic lz, input int c);
    logic [3:0] ed;
    logic [6:0] es;
    logic [3:0] ea;
    exp_cyc(s, lz, c, ed, es, ea);
    chk($sformatf("digit_en %s c%0d", tag, c), 32'(digit_en), 32'(ed));
    chk($sformatf("segments %s c%0d", tag, c), 32'(segments), 32'(es));
    chk($sformatf("dec_address %s c%0d", tag, c), 32'(dec_address),
        32'(ea));
  endtask

  initial begin
    logic [15:0] m;
    int nz;
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    lz_blank = 1'b0;
    shadow_m = 16'h0;

    mode[0] = 1; val[0] = 16'h1A3F; lzc[0] = 1'b0; s_c[0] = 3; e_c[0] = 0;
    mode[1] = 1; val[1] = 16'h00C5; lzc[1] = 1'b0; s_c[1] = 3; e_c[1] = 0;
    mode[2] = 1; val[2] = 16'h0005; lzc[2] = 1'b0; s_c[2] = 9; e_c[2] = 0;
    mode[3] = 2; val[3] = 16'h7777; lzc[3] = 1'b1; s_c[3] = 5; e_c[3] = 20;
    mode[4] = 1; val[4] = 16'h0000; lzc[4] = 1'b1; s_c[4] = 31; e_c[4] = 0;
    mode[5] = 0; val[5] = 16'hBEEF; lzc[5] = 1'b1; s_c[5] = 10; e_c[5] = 0;
    for (int f = 6; f < NFR; f++) begin
      mode[f] = int'($urandom_range(0, 2));
      nz      = int'($urandom_range(0, 4));
      m       = 16'hFFFF;
      m       = m >> (4 * nz);
      val[f]  = 16'($urandom) & m;
      lzc[f]  = 1'($urandom_range(0, 1));
      s_c[f]  = int'($urandom_range(1, 15));
      e_c[f]  = int'($urandom_range(s_c[f] + 1, 29));
      if (mode[f] == 1) s_c[f] = int'($urandom_range(1, 31));
    end

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    fork
      begin : monitor
        rec_t r;
        int w;
        bit ok;
        ok = 1'b1;
        for (int f = 0; f < NFR && ok; f++) begin
          if (f == 0) begin
            @(negedge clock);
          end else begin
            w = 0;
            do begin
              @(negedge clock);
              w++;
            end while (frame_done !== 1'b1 && w < 40);
            chk($sformatf("frame_period f%0d", f), 32'(w), 32'd1);
            if (frame_done !== 1'b1) ok = 1'b0;
          end
          if (ok) begin
            if (sb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL scoreboard f%0d: got empty queue expected entry",
                       f);
              ok = 1'b0;
            end else begin
              r = sb.pop_front();
              for (int c = 0; c < FR; c++) begin
                if (c > 0) @(negedge clock);
                check_cycle($sformatf("f%0d", f), r.sh, r.lz, c);
                chk($sformatf("frame_done f%0d c%0d", f, c),
                    32'(frame_done), 32'(c == 0 && !r.first));
                chk($sformatf("load_ack f%0d c%0d", f, c),
                    32'(load_ack), 32'(c == 0 && r.ack && !r.first));
                chk($sformatf("one_low f%0d c%0d", f, c),
                    32'($countones(~digit_en) <= 1), 32'd1);
                chk($sformatf("ack_w_fdone f%0d c%0d", f, c),
                    32'(!load_ack || frame_done), 32'd1);
              end
            end
          end
        end
      end
      begin : stimulus
        rec_t r;
        logic ack_pend;
        ack_pend = 1'b0;
        for (int f = 0; f < NFR; f++) begin
          lz_blank = lzc[f];
          load     = 1'b0;
          r.sh     = shadow_m;
          r.lz     = lzc[f];
          r.ack    = ack_pend;
          r.first  = (f == 0);
          sb.push_back(r);
          for (int c = 0; c < FR; c++) begin
            if (c > 0) begin
              @(posedge clock);
              #1;
            end
            case (mode[f])
              0: if (c == s_c[f]) value = 16'($urandom);
              1: if (c == s_c[f]) begin
                   value = val[f];
                   load  = 1'b1;
                 end
              default: begin
                if (c == s_c[f]) begin
                  value = val[f];
                  load  = 1'b1;
                end
                if (c == e_c[f]) load = 1'b0;
                if (c == e_c[f] + 2) value = 16'($urandom);
              end
            endcase
          end
          ack_pend = load;
          if (load) shadow_m = value;
          @(posedge clock);
          #1;
        end
        load = 1'b0;
      end
    join

    lz_blank = 1'b0;
    repeat (21) @(posedge clock);
    #1;
    check_cycle("pre_reset", shadow_m, 1'b0, 21);
    reset = 1'b1;
    #1;
    chk("reset segments", 32'(segments), 32'h7F);
    chk("reset digit_en", 32'(digit_en), 32'hF);
    chk("reset dec_address", 32'(dec_address), 32'h0);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    chk("reset load_ack", 32'(load_ack), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check_cycle("post_reset", 16'h0, 1'b0, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scanner.md
Name: sevenseg_scanner

Overview:
- Time-multiplexed display controller for the multiplier's result, driving a 4-digit common-anode hex display.
- Owns one shared sevenseg decoder: presents each digit's nibble on dec_address, takes the decoded pattern back on dec_data, and drives segments plus one active-low digit enable per digit.
- Inserts a blanking gap between digit slots to prevent ghosting.
- Captures new values only at frame boundaries, through a load/ack handshake.

Parameters:
- NDIGITS, 4: number of digits scanned; value width is 4*NDIGITS.
- PRESCALE, 50000: clock cycles per digit slot; must be greater than BLANK.
- BLANK, 16: cycles at the start of each slot with all digits off; must be at least 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*NDIGITS  hex value to display; nibble k drives digit k, digit 0 least significant.
- load  in  1  update request; held high, with value stable, until load_ack.
- load_ack  out  1  one-cycle pulse: value captured into the shadow register.
- lz_blank  in  1  1 = suppress leading zeros; sampled live.
- dec_address  out  4  nibble presented to the shared decoder.
- dec_data  in  7  active-low pattern returned by the decoder (combinational).
- segments  out  7  active-low segment drive, registered.
- digit_en  out  NDIGITS  active-low digit enables, registered; at most one low at any time.
- frame_done  out  1  one-cycle pulse after the last digit's slot ends.

Behaviour:
- Reset values, applied immediately on reset assertion, including mid-frame:
  - segments = 7'b1111111; digit_en = all ones; dec_address = 0.
  - load_ack = 0; frame_done = 0.
  - shadow = 0; idx = 0; cnt = 0; state = S_BLANK.
- State S_BLANK, cnt 0..BLANK-1:
  - digit_en all ones, segments all ones.
  - dec_address = shadow[idx], so the decoder output settles before display.
  - At cnt = BLANK-1: go to S_SHOW.
- State S_SHOW, cnt BLANK..PRESCALE-1:
  - Digit visible: digit_en[idx] = 0; segments <= dec_data, registered every cycle; dec_address held.
  - Digit blanked: digit_en all ones, segments all ones.
  - At cnt = PRESCALE-1: cnt <= 0, idx <= idx+1 (wrapping NDIGITS-1 -> 0), state <= S_BLANK.
- Slot length is exactly PRESCALE cycles; frame length is exactly NDIGITS*PRESCALE cycles.
- Register timing: segments and digit_en change on the same edge. First visible cycle is the edge at which cnt reaches BLANK; last visible cycle ends at the edge where cnt wraps to 0.
- Leading-zero blanking: digit k (k ≥ 1) is blanked when lz_blank = 1 and shadow nibbles k..NDIGITS-1 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Frame boundary is the clock edge ending digit NDIGITS-1's S_SHOW. On that edge:
  - frame_done <= 1 for one cycle.
  - If load = 1: shadow <= value and load_ack <= 1, in the same cycle as frame_done.
  - New shadow contents first appear on dec_address in digit 0's S_BLANK.
- load is sampled only at the frame boundary:
  - Asserted in the boundary cycle itself: captured.
  - Deasserted before the boundary: no capture, no ack.
  - Held high after ack: recaptured at the next boundary. The requester must drop load on ack.
- No other path modifies shadow. Mid-frame changes to value have no effect on the display.
- dec_data is unused outside S_SHOW.

Test Plan (NDIGITS=4, PRESCALE=8, BLANK=2):
- Reset mid-frame: assert reset at idx=2, cnt=5 -> same cycle: segments=7F, digit_en=4'hF, dec_address=0. After release: idx=0, S_BLANK.
- Scan order: load value=16'h1A3F, lz_blank=0, sevenseg decoder attached.
  - Frame after ack: digit_en goes E,D,B,7 for 6 cycles each, each preceded by 2 cycles of F.
  - segments = 0E (F), 30 (3), 08 (A), 79 (1).
  - frame_done pulses every 32 cycles.
- Handshake: raise load at cycle 3 of a frame with value=16'h00C5 -> load_ack and frame_done pulse together at cycle 32. Shadow unchanged before then. Change value at cycle 10 -> no display change.
- Leading-zero blanking: shadow=16'h0005, lz_blank=1 -> only digit 0 enabled (segments 12); digits 1-3 keep digit_en=F and segments=7F. shadow=0 -> digit 0 shows 40.
- Late withdrawal: load high from cycle 5 to 20, then low -> no load_ack at the boundary, shadow unchanged.
- Invariants (assertions): at most one digit_en bit low at any time; no digit enabled during BLANK cycles; load_ack only ever coincident with frame_done.
